operand_align_shift: RTL

- Alignment stage directly downstream of the operand swap multiplexer in the floating-to-fixed linearizer/normalizer path.
- Receives two IEEE-754 operands already ordered so that dmaj_i has the larger exponent and dmin_i the smaller.
- Right-shifts the minor significand iteratively until both share the major exponent, keeping guard/round bits and a sticky bit, then presents both significands to the adder/normalizer with a one-cycle ready pulse.

---
 rtl/operand_align_shift.sv | 114 +++++++++++
 1 files changed

// File: rtl/operand_align_shift.sv
// Alignment stage after the operand swap mux: right-shifts the minor significand
// to the major exponent, keeping guard/round bits and a sticky bit.
module operand_align_shift #(
    parameter int W  = 32,
    parameter int EW = 8,
    parameter int SW = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          beg_align_i,
    input  logic [W-1:0]  dmaj_i,
    input  logic [W-1:0]  dmin_i,
    output logic          sign_maj_o,
    output logic          sign_min_o,
    output logic [EW-1:0] exp_o,
    output logic [SW:0]   mant_maj_o,
    output logic [SW+2:0] mant_min_o,
    output logic          sticky_o,
    output logic          swap_err_o,
    output logic          busy_o,
    output logic          ready_o
);
    // state   | meaning
    // IDLE    | waiting for beg_align_i
    // SHIFT   | shifting minor significand one bit per cycle until count is 0
    // DONE    | one-cycle ready pulse; may accept a new start back-to-back
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int MAXSH = SW + 3;
    localparam int CW    = $clog2(MAXSH + 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_count;
    logic          r_sign_maj;
    logic          r_sign_min;
    logic [EW-1:0] r_exp;
    logic [SW:0]   r_mant_maj;
    logic [SW+2:0] r_mant_min;
    logic          r_sticky;
    logic          r_swap_err;

    logic [EW-1:0] w_exp_maj;
    logic [EW-1:0] w_exp_min;
    logic          w_hid_maj;
    logic          w_hid_min;
    logic [EW-1:0] w_eff_maj;
    logic [EW-1:0] w_eff_min;
    logic          w_swap;
    logic [EW-1:0] w_diff;
    logic [CW-1:0] w_cnt;
    logic          w_capture;

    assign w_exp_maj = dmaj_i[W-2 -: EW];
    assign w_exp_min = dmin_i[W-2 -: EW];
    assign w_hid_maj = (w_exp_maj != '0);
    assign w_hid_min = (w_exp_min != '0);
    // Denormals and zero share the exponent of the smallest normal.
    assign w_eff_maj = w_hid_maj ? w_exp_maj : EW'(1);
    assign w_eff_min = w_hid_min ? w_exp_min : EW'(1);
    assign w_swap    = (w_eff_min > w_eff_maj);
    assign w_diff    = w_swap ? '0 : (w_eff_maj - w_eff_min);
    assign w_cnt     = (w_diff > EW'(MAXSH)) ? CW'(MAXSH) : w_diff[CW-1:0];
    assign w_capture = beg_align_i && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_sign_maj <= 1'b0;
            r_sign_min <= 1'b0;
            r_exp      <= '0;
            r_mant_maj <= '0;
            r_mant_min <= '0;
            r_sticky   <= 1'b0;
            r_swap_err <= 1'b0;
        end else if (w_capture) begin
            r_state    <= S_SHIFT;
            r_count    <= w_cnt;
            r_sign_maj <= dmaj_i[W-1];
            r_sign_min <= dmin_i[W-1];
            r_exp      <= w_eff_maj;
            r_mant_maj <= {w_hid_maj, dmaj_i[SW-1:0]};
            r_mant_min <= {w_hid_min, dmin_i[SW-1:0], 2'b00};
            r_sticky   <= 1'b0;
            r_swap_err <= w_swap;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    if (r_count != '0) begin
                        r_mant_min <= r_mant_min >> 1;
                        r_sticky   <= r_sticky | r_mant_min[0];
                        r_count    <= r_count - CW'(1);
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sign_maj_o = r_sign_maj;
    assign sign_min_o = r_sign_min;
    assign exp_o      = r_exp;
    assign mant_maj_o = r_mant_maj;
    assign mant_min_o = r_mant_min;
    assign sticky_o   = r_sticky;
    assign swap_err_o = r_swap_err;
    assign busy_o     = (r_state == S_SHIFT);
    assign ready_o    = (r_state == S_DONE);
endmodule
